// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial wide adder sequencer.
package cla_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Width of an index over n items, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequences a wide add through an external registered 4-bit adder, one nibble at
// a time LSB first, chaining the carry and publishing the full sum with a done pulse.
module nibble_serial_adder_ctrl
  import cla_pkg::*;
#(
  parameter int unsigned NIBBLES   = 4,
  parameter int unsigned ADDER_LAT = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_in,
  input  logic [NIBBLE_W*NIBBLES-1:0]    A_in,
  input  logic [NIBBLE_W*NIBBLES-1:0]    B_in,
  input  logic                           C0_in,
  output logic                           busy_out,
  output logic                           done_out,
  output logic [NIBBLE_W*NIBBLES-1:0]    S_out,
  output logic                           Cout_out,
  output logic [NIBBLE_W-1:0]            add_A_out,
  output logic [NIBBLE_W-1:0]            add_B_out,
  output logic                           add_C0_out,
  input  logic [NIBBLE_W-1:0]            add_S_in,
  input  logic                           add_C4_in
);

  localparam int unsigned W    = NIBBLE_W * NIBBLES;
  localparam int unsigned NibW = idx_width(NIBBLES);
  localparam logic [NibW-1:0] NibLast = NibW'(NIBBLES - 1);
  localparam logic [3:0]      CntLast = 4'(ADDER_LAT);

  state_e              state_q;
  logic [W-1:0]        a_q, b_q, res_q, s_q;
  logic [NibW-1:0]     nib_q;
  logic [3:0]          cnt_q;
  logic [NIBBLE_W-1:0] add_a_q, add_b_q;
  logic                carry_q, busy_q, done_q, cout_q;

  logic [W-1:0]        res_cap;
  logic [NibW-1:0]     nib_nx;
  logic [NIBBLE_W-1:0] a_next, b_next;

  // Result with the current adder nibble merged in, plus the operands for the next nibble.
  always_comb begin
    res_cap = res_q;
    res_cap[NIBBLE_W*nib_q +: NIBBLE_W] = add_S_in;
    nib_nx = nib_q + NibW'(1);
    a_next = a_q[NIBBLE_W*nib_nx +: NIBBLE_W];
    b_next = b_q[NIBBLE_W*nib_nx +: NIBBLE_W];
  end

  // Control FSM; every output is a register so the adder sees glitch-free operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      nib_q   <= '0;
      cnt_q   <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start_in) begin
            a_q     <= A_in;
            b_q     <= B_in;
            carry_q <= C0_in;
            res_q   <= '0;
            nib_q   <= '0;
            cnt_q   <= '0;
            add_a_q <= A_in[NIBBLE_W-1:0];
            add_b_q <= B_in[NIBBLE_W-1:0];
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (cnt_q == CntLast) begin
            res_q <= res_cap;
            if (nib_q == NibLast) begin
              // Adder drive returns to zero; the final carry lives only in cout_q.
              s_q     <= res_cap;
              cout_q  <= add_C4_in;
              carry_q <= 1'b0;
              add_a_q <= '0;
              add_b_q <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              carry_q <= add_C4_in;
              nib_q   <= nib_nx;
              cnt_q   <= '0;
              add_a_q <= a_next;
              add_b_q <= b_next;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_out   = busy_q;
  assign done_out   = done_q;
  assign S_out      = s_q;
  assign Cout_out   = cout_q;
  assign add_A_out  = add_a_q;
  assign add_B_out  = add_b_q;
  assign add_C0_out = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench: the driver pushes expected sums, a monitor pops them on done_out.
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned L = 2;
  localparam int unsigned W = 4 * N;
  localparam int unsigned Period = N * (L + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start_in = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         c0_in = 1'b0;
  logic         busy_out, done_out, Cout_out, add_C0_out, add_C4_in;
  logic [W-1:0] S_out;
  logic [3:0]   add_A_out, add_B_out, add_S_in;

  nibble_serial_adder_ctrl #(.NIBBLES(N), .ADDER_LAT(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_in   (start_in),
    .A_in       (a_in),
    .B_in       (b_in),
    .C0_in      (c0_in),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .S_out      (S_out),
    .Cout_out   (Cout_out),
    .add_A_out  (add_A_out),
    .add_B_out  (add_B_out),
    .add_C0_out (add_C0_out),
    .add_S_in   (add_S_in),
    .add_C4_in  (add_C4_in)
  );

  // Stand-in for the registered 4-bit adder: two register stages of latency.
  logic [4:0] p1, p2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      p1 <= {1'b0, add_A_out} + {1'b0, add_B_out} + {4'd0, add_C0_out};
      p2 <= p1;
    end
  end
  assign add_S_in  = p2[3:0];
  assign add_C4_in = p2[4];

  typedef struct {
    logic [W:0]  res;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [W:0]  last_res = '0;
  int unsigned cyc = 0;
  int unsigned tot = 0;
  int unsigned pass = 0;
  int unsigned prev_acc = 0;
  bit          prev_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Carry entering nibble k, from plain arithmetic on the low 4k bits.
  function automatic logic cin_at(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, input int k);
    logic [W:0] m, s;
    m = (17'd1 << (4 * k)) - 17'd1;
    s = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, c};
    return s[4*k];
  endfunction

  // Monitor: pop on done, otherwise the published result must hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done_out) begin
        if (exp_q.size() == 0) begin
          tot++;
          $display("FAIL unexpected_done: got done_out=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("sum_cout", {15'd0, Cout_out, S_out}, {15'd0, e.res});
          check("done_latency", cyc, e.cyc);
          last_res = e.res;
        end
      end else begin
        check("result_hold", {15'd0, Cout_out, S_out}, {15'd0, last_res});
      end
    end
  end

  // mode 0: single pulse; 1: extra start pulse while busy; 2: start held high.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input int mode);
    exp_t e;
    int   k;
    @(negedge clk);
    a_in = a; b_in = b; c0_in = c; start_in = 1'b1;
    @(posedge clk); #1;
    if (mode == 2 && prev_hold) check("b2b_interval", cyc - prev_acc, Period + 2);
    prev_acc  = cyc;
    prev_hold = (mode == 2);
    e.res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.cyc = cyc + Period;
    exp_q.push_back(e);
    if (mode != 2) start_in = 1'b0;
    check("busy_run", {31'd0, busy_out}, 32'd1);
    for (int i = 0; i < int'(Period); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      k = i / (L + 1);
      check("add_a", {28'd0, add_A_out}, {28'd0, a[4*k +: 4]});
      check("add_b", {28'd0, add_B_out}, {28'd0, b[4*k +: 4]});
      check("add_c0", {31'd0, add_C0_out}, {31'd0, cin_at(a, b, c, k)});
      if (mode == 1 && i == 4) begin start_in = 1'b1; a_in = 16'hAAAA; b_in = 16'($urandom); end
      if (mode == 1 && i == 5) start_in = 1'b0;
    end
    @(posedge clk); #1;
    check("busy_in_done", {31'd0, busy_out}, 32'd0);
    check("done_pulse", {31'd0, done_out}, 32'd1);
    check("add_idle", {23'd0, add_A_out, add_B_out, add_C0_out}, 32'd0);
    @(posedge clk); #1;
    check("done_single", {31'd0, done_out}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {4'd0, busy_out, done_out, Cout_out, S_out, add_A_out, add_B_out, add_C0_out},
          32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_hold");
    @(negedge clk) rst = 1'b0;
    #1 check_all_zero("reset_release");

    do_op(16'h0044, 16'h0044, 1'b1, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 0);
    do_op(16'h1111, 16'h2222, 1'b0, 1);

    // Asynchronous reset in nibble 2 discards the operation.
    @(negedge clk);
    a_in = 16'h00FF; b_in = 16'h0001; c0_in = 1'b0; start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    last_res = '0;
    #1 check_all_zero("reset_async");
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (Period + 4) @(posedge clk);
    #1 check_all_zero("reset_no_done");

    do_op(16'h1234, 16'h4321, 1'b0, 0);

    for (int n = 0; n < 4; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_op(ra, rb, 1'($urandom), 2);
    end
    for (int n = 0; n < 20; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_op(ra, rb, 1'($urandom), 0);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

endmodule
